i2c_ram_slave: RTL

- Parametrised I2C target that exposes a byte-wide register RAM of 2^ADDR_W entries to an external I2C controller.
- Successor to the fixed 8-byte I2C RAM top. Adds:
  - configurable depth and device address;
  - pointer auto-increment with wrap-around;
  - repeated-START reads;
  - address-mismatch NACK;
  - a parallel fabric read port and a write strobe, so on-chip logic can consume RAM contents.
- Sits behind the tt_um top; SCL/SDA come from uio_in, and SDA output enable goes to uio_oe.

---
 rtl/i2c_ram_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_ram_slave.sv
// I2C target exposing a 2^ADDR_W byte register RAM, with auto-incrementing
// pointer, repeated-START reads and a parallel fabric read port.
module i2c_ram_slave #(
  parameter int unsigned ADDR_W      = 3,
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] fab_raddr,
  output logic [7:0]        fab_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, PTR, PTRACK, WDATA, WACK, RDATA, RACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   sda_oe_q, sda_oe_d, busy_q, busy_d, we;
  logic [7:0]             mem_q [DEPTH];
  logic [7:0]             mem_d [DEPTH];
  logic [7:0]             byte_in;

  // Synchroniser chains plus one history flop for edge detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser registers, idle-high bus after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + ADDR_W'(1);

  // Protocol FSM: bits sampled on SCL rise, SDA drive updated on SCL fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    mem_d     = mem_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_addr_d = wr_addr_q;
    we        = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      state_d  = DEVADDR;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        DEVADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              state_d = DEVACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // ACK is asserted on the first SCL fall and released on the second;
        // a read starts driving its MSB at that same release edge.
        DEVACK, PTRACK, WACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            if (state_q == DEVACK && shift_q[0]) begin
              state_d  = RDATA;
              shift_d  = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
            end else if (state_q == DEVACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ptr_d   = byte_in[ADDR_W-1:0];
            state_d = PTRACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            we           = 1'b1;
            mem_d[ptr_q] = byte_in;
            wr_addr_d    = ptr_q;
            ptr_d        = ptr_inc;
            state_d      = WACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = RACK;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        RACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_s) begin
              ptr_d   = ptr_inc;
              shift_d = mem_q[ptr_inc];
              cnt_d   = '0;
              state_d = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Protocol state, pointer and RAM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      mem_q     <= mem_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = we;
  assign wr_addr   = we ? ptr_q : wr_addr_q;
  assign fab_rdata = mem_q[fab_raddr];

endmodule
